rptr_empty: RTL
===============

# rptr_empty

Read-domain pointer and empty-flag controller for the asynchronous FIFO. It sits directly downstream of the write-to-read pointer synchronizer and consumes the two-flop-synchronized Gray write pointer `rq2_wptr`. From it, the block maintains the read pointer, drives the FIFO memory read address, and produces registered empty, almost-empty, occupancy and underflow status. The Gray read pointer it produces feeds the read-to-write synchronizer.

## Interface
- `ADDRSIZE`, default 4: FIFO depth is 2^ADDRSIZE; pointers are ADDRSIZE+1 bits wide.
- `AEMPTY_THRESH`, default 2: `raempty` asserts when occupancy ≤ this value.

- `rclk`  in  1  read-domain clock. One clock only; all logic is on the rising edge.
- `rrst`  in  1  synchronous, active-high reset.
- `rinc`  in  1  read request; honoured only when `rempty`=0.
- `rq2_wptr`  in  ADDRSIZE+1  Gray write pointer, already synchronized into `rclk`.
- `raddr`  out  ADDRSIZE  binary read address to the FIFO memory; equals `rbin[ADDRSIZE-1:0]`.
- `rptr`  out  ADDRSIZE+1  registered Gray read pointer, sent to the read-to-write synchronizer.
- `rempty`  out  1  registered empty flag.
- `raempty`  out  1  registered almost-empty flag.
- `rlevel`  out  ADDRSIZE+1  registered occupancy as seen from the read domain, range 0..2^ADDRSIZE.
- `runderflow`  out  1  sticky flag: a read was attempted while empty.

## Operation
- **Read accept:** `ren = rinc & ~rempty`.
- **Next binary pointer:** `rbinnext = rbin + ren`, modulo 2^(ADDRSIZE+1).
- **Next Gray pointer:** `rgraynext = (rbinnext >> 1) ^ rbinnext`.
- **Empty:** `rempty_next = (rgraynext == rq2_wptr)`, a full-width compare that includes the wrap MSB.
- **Level:**
  - `wbin_s = gray2bin(rq2_wptr)`.
  - `rlevel_next = wbin_s - rbinnext`, modulo 2^(ADDRSIZE+1).
- **Almost-empty:** `raempty_next = (rlevel_next <= AEMPTY_THRESH)`.
- **Underflow:** `runderflow` is set on `rinc & rempty` and cleared only by `rrst`.
- **Register update:** all state registers (`rbin`, `rptr`, `rempty`, `raempty`, `rlevel`, `runderflow`) load their `_next` values every cycle.
- **Reset values:**
  - `rbin`=0, `rptr`=0, `raddr`=0, `rlevel`=0, `runderflow`=0.
  - `rempty`=1, `raempty`=1.
- **Reset precedence:** reset overrides `rinc` in the same cycle. A mid-operation reset zeroes the pointers regardless of `rq2_wptr`; the write side must be reset together with the read side.
- **Read while empty:** the pointer holds, no memory address advance occurs, and only `runderflow` is affected.
- **Flag pessimism:** flags are pessimistic by design. Because `rq2_wptr` lags the true write pointer, `rempty` and `raempty` may stay asserted longer than necessary but never deassert early.

## Timing
- **Read accept:** `rinc`=1 with `rempty`=0 at edge N gives `rbin`/`raddr`/`rptr` advanced after edge N. Read data at the old `raddr` is consumed during cycle N.
- **Empty update:** empty status reflecting a read at edge N is valid after edge N, with 0 extra latency.
- **Write visibility:** a change on `rq2_wptr` appears in `rempty`/`rlevel`/`raempty` one `rclk` edge later.
- **Simultaneous events:** a read and a pointer change in the same cycle combine in `rlevel_next`, giving a net result; e.g. level 1 with one read and one write stays at 1.
- **Wrap-around:** after 2^(ADDRSIZE+1) reads, `rbin` returns to 0. Empty detection stays correct because the MSB is included in the compare.
- **Maximum level:** 2^ADDRSIZE; for the default, `rq2_wptr` Gray 11000 against `rptr` 00000 gives `rlevel`=16.

## Structure
- **Shared package** `fifo_pkg`:
  - Pointer width function `PTRW = ADDRSIZE+1`.
  - `bin2gray`/`gray2bin` functions.
  - Reset constants for the flags.
- **Sub-module** `gray2bin`: parameterized combinational XOR-prefix converter. It is instantiated for `rq2_wptr`, and the write-side full controller reuses it.

## Test plan
- **Reset:** assert `rrst` for 2 cycles with random `rq2_wptr` → `rempty`=1, `raempty`=1, `rlevel`=0, `rptr`=0, `raddr`=0, `runderflow`=0.
- **First write:** step `rq2_wptr` 00000→00001 → next edge `rempty`=0, `rlevel`=1, `raempty`=1. Then one `rinc` → `rptr`=00001, `raddr`=1, `rempty`=1, `rlevel`=0.
- **Fill and drain:** set `rq2_wptr`=11000 (16 writes) → `rlevel`=16, `raempty`=0. Read 13 entries → `raempty` rises on the 14th read (`rlevel`=2). Continue reading to `rlevel`=0 → `rempty`=1.
- **Wrap-around:** run 40 write/read pairs through the 5-bit pointers → `rptr` follows the Gray sequence and wraps 10000→00000 correctly; `rempty` is never spuriously 0 with equal pointers.
- **Underflow:** `rinc`=1 for 3 cycles while empty → `rbin` unchanged, `runderflow`=1 from the first cycle and held until `rrst`.
- **Reset mid-operation:** at `rlevel`=5, assert `rrst` together with `rinc` → all outputs return to their reset values on that edge; the read is not counted.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer controllers:
// pointer width, Gray conversion helpers and flag reset values.
package fifo_pkg;

    localparam int ADDRSIZE_DEFAULT = 4;
    localparam int CONV_W           = 32;

    localparam logic REMPTY_RST     = 1'b1;
    localparam logic RAEMPTY_RST    = 1'b1;
    localparam logic RUNDERFLOW_RST = 1'b0;

    function automatic int ptrw(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Zero-extended Gray codes convert correctly at full width.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin = '0;
        for (int i = CONV_W - 1; i >= 0; i--) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Parameterized combinational Gray-to-binary converter (XOR prefix from the MSB).
// Shared by the read-side empty and write-side full controllers.
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/rptr_empty.sv
// Read-domain pointer and empty/almost-empty/level/underflow status for the
// asynchronous FIFO, driven by the synchronized Gray write pointer.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE      = ADDRSIZE_DEFAULT,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rinc,
    input  logic [ADDRSIZE:0]     rq2_wptr,
    output logic [ADDRSIZE-1:0]   raddr,
    output logic [ADDRSIZE:0]     rptr,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDRSIZE:0]     rlevel,
    output logic                  runderflow
);

    localparam int              PTRW      = ptrw(ADDRSIZE);
    localparam logic [PTRW-1:0] AE_THRESH = PTRW'(AEMPTY_THRESH);

    logic [PTRW-1:0] rbin_q, rbin_d;
    logic [PTRW-1:0] rptr_q, rptr_d;
    logic [PTRW-1:0] rlevel_q, rlevel_d;
    logic            rempty_q, rempty_d;
    logic            raempty_q, raempty_d;
    logic            runderflow_q, runderflow_d;

    logic            ren;
    logic [PTRW-1:0] wbin_s;

    gray2bin #(
        .W (PTRW)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin_s)
    );

    always_comb begin
        ren          = rinc & ~rempty_q;
        rbin_d       = rbin_q + {{(PTRW-1){1'b0}}, ren};
        rptr_d       = (rbin_d >> 1) ^ rbin_d;
        // Full-width compare: the MSB separates "empty" from "wrapped full".
        rempty_d     = (rptr_d == rq2_wptr);
        rlevel_d     = wbin_s - rbin_d;
        raempty_d    = (rlevel_d <= AE_THRESH);
        runderflow_d = runderflow_q | (rinc & rempty_q);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rlevel_q     <= '0;
            rempty_q     <= REMPTY_RST;
            raempty_q    <= RAEMPTY_RST;
            runderflow_q <= RUNDERFLOW_RST;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rlevel_q     <= rlevel_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign raempty    = raempty_q;
    assign rlevel     = rlevel_q;
    assign runderflow = runderflow_q;

endmodule
